// File: rtl/rsa_ctrl.sv
// Bus-mapped front end for the rsa modular-exponentiation engine.
// It holds the operand registers, runs the start/done handshake, latches C and counts run cycles.
module rsa_ctrl #(
    parameter int WIDTH  = 64,
    parameter int E_BITS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_sel,
    input  logic              bus_we,
    input  logic [7:0]        bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              irq,
    output logic              rsa_start,
    output logic [WIDTH-1:0]  rsa_M,
    output logic [WIDTH-1:0]  rsa_N,
    output logic [WIDTH-1:0]  rsa_N_INV,
    output logic [WIDTH-1:0]  rsa_R2,
    output logic [E_BITS-1:0] rsa_E,
    input  logic [WIDTH-1:0]  rsa_C,
    input  logic              rsa_done
);
    localparam int WW = WIDTH / 32;
    localparam int EW = E_BITS / 32;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  m_q, n_q, ninv_q, r2_q, c_q;
    logic [E_BITS-1:0] e_q;
    logic [31:0]       cycles_q, rdata_q, rd_word;
    logic              irq_en_q, stat_done_q, err_q, rsa_done_q, start_q;

    logic [2:0] region;
    int         wi;
    logic       wr, rd, busy, ctrl_wr, op_wr, start_req, clr_req, complete;

    // Each operand occupies a 32-byte window: addr[7:5] selects it, addr[4:2] the word.
    assign region    = bus_addr[7:5];
    assign wi        = int'(bus_addr[4:2]);
    assign wr        = bus_sel & bus_we;
    assign rd        = bus_sel & ~bus_we;
    assign busy      = (state_q != S_IDLE);
    assign ctrl_wr   = wr && (bus_addr[7:2] == 6'd0);
    assign op_wr     = wr && (region >= 3'd1) && (region <= 3'd5);
    assign start_req = ctrl_wr & bus_wdata[0];
    assign clr_req   = ctrl_wr & bus_wdata[2];
    assign complete  = (state_q == S_WAIT) && rsa_done && !rsa_done_q;

    always_comb begin
        rd_word = '0;
        case (region)
            3'd0: begin
                case (bus_addr[4:2])
                    3'd0:    rd_word = {30'd0, irq_en_q, 1'b0};
                    3'd1:    rd_word = {29'd0, err_q, stat_done_q, busy};
                    3'd2:    rd_word = cycles_q;
                    default: rd_word = '0;
                endcase
            end
            3'd1: if (wi < WW) rd_word = m_q[32*wi +: 32];
            3'd2: if (wi < EW) rd_word = e_q[32*wi +: 32];
            3'd3: if (wi < WW) rd_word = n_q[32*wi +: 32];
            3'd4: if (wi < WW) rd_word = ninv_q[32*wi +: 32];
            3'd5: if (wi < WW) rd_word = r2_q[32*wi +: 32];
            3'd6: if (wi < WW) rd_word = c_q[32*wi +: 32];
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            m_q         <= '0;
            n_q         <= '0;
            ninv_q      <= '0;
            r2_q        <= '0;
            e_q         <= '0;
            c_q         <= '0;
            cycles_q    <= '0;
            rdata_q     <= '0;
            irq_en_q    <= 1'b0;
            stat_done_q <= 1'b0;
            err_q       <= 1'b0;
            rsa_done_q  <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            rsa_done_q <= rsa_done;
            if (rd) rdata_q <= rd_word;
            if (ctrl_wr) irq_en_q <= bus_wdata[1];

            if (op_wr && !busy) begin
                case (region)
                    3'd1: if (wi < WW) m_q[32*wi +: 32]    <= bus_wdata;
                    3'd2: if (wi < EW) e_q[32*wi +: 32]    <= bus_wdata;
                    3'd3: if (wi < WW) n_q[32*wi +: 32]    <= bus_wdata;
                    3'd4: if (wi < WW) ninv_q[32*wi +: 32] <= bus_wdata;
                    3'd5: if (wi < WW) r2_q[32*wi +: 32]   <= bus_wdata;
                    default: ;
                endcase
            end

            // Clear is applied first so a same-cycle set (completion or new error) wins.
            if (clr_req) begin
                stat_done_q <= 1'b0;
                err_q       <= 1'b0;
            end
            if (busy && (start_req || op_wr)) err_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        stat_done_q <= 1'b0;
                        cycles_q    <= '0;
                        start_q     <= 1'b1;
                        state_q     <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    start_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cycles_q != 32'hFFFF_FFFF) cycles_q <= cycles_q + 32'd1;
                    if (complete) begin
                        c_q         <= rsa_C;
                        stat_done_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_rdata = rdata_q;
    assign irq       = stat_done_q & irq_en_q;
    assign rsa_start = start_q;
    assign rsa_M     = m_q;
    assign rsa_N     = n_q;
    assign rsa_N_INV = ninv_q;
    assign rsa_R2    = r2_q;
    assign rsa_E     = e_q;
endmodule

// File: tb/tb_rsa_ctrl.sv
// Bench for rsa_ctrl: register vector table, stub engine runs, busy-error and reset-mid-run sequences.
module tb_rsa_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        bus_sel, bus_we;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        irq, rsa_start, rsa_done;
    logic [63:0] rsa_M, rsa_N, rsa_N_INV, rsa_R2, rsa_E, rsa_C;

    rsa_ctrl #(.WIDTH(64), .E_BITS(64)) dut (
        .clk(clk), .rst(rst), .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq), .rsa_start(rsa_start),
        .rsa_M(rsa_M), .rsa_N(rsa_N), .rsa_N_INV(rsa_N_INV), .rsa_R2(rsa_R2),
        .rsa_E(rsa_E), .rsa_C(rsa_C), .rsa_done(rsa_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    localparam logic [63:0] NINV = 64'd15092790605762360413;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e,
                                           input logic [63:0] n);
        logic [127:0] r, x;
        r = 128'd1;
        x = {64'd0, b} % {64'd0, n};
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * x) % {64'd0, n};
            x = (x * x) % {64'd0, n};
        end
        return r[63:0];
    endfunction

    // Stub engine: done rises so it is sampled 20 cycles after the start pulse and then stays high.
    // While hold is set, starts are ignored; dropping hold launches a fresh run.
    logic        stub_hold = 1'b0, hold_q, stub_act, use_model = 1'b0;
    int          stub_cnt;
    logic [63:0] stub_c = 64'h0123_4567_89AB_CDEF;
    always @(posedge clk) begin
        if (rst) begin
            rsa_done <= 1'b0;
            stub_act <= 1'b0;
            stub_cnt <= 0;
            hold_q   <= 1'b0;
            rsa_C    <= '0;
        end else begin
            hold_q <= stub_hold;
            if ((rsa_start && !stub_hold) || (hold_q && !stub_hold)) begin
                rsa_done <= 1'b0;
                stub_act <= 1'b1;
                stub_cnt <= 1;
                rsa_C    <= use_model ? modexp(rsa_M, rsa_E, rsa_N) : stub_c;
            end else if (stub_act) begin
                if (stub_cnt == 19) begin
                    rsa_done <= 1'b1;
                    stub_act <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt + 1;
                end
            end
        end
    end

    always @(posedge clk) if (!rst && rsa_start) pulses++;

    // Read scoreboard: expectation queued when the read is driven, compared when rdata is valid.
    typedef struct {
        logic [31:0] exp;
        string       nm;
    } rexp_t;
    rexp_t rq[$];

    always @(posedge clk) begin
        if (!rst && bus_sel && !bus_we) begin
            rexp_t e;
            #1;
            if (rq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: unexpected read data %h", bus_rdata);
            end else begin
                e = rq.pop_front();
                check(e.nm, {32'd0, bus_rdata}, {32'd0, e.exp});
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_sel = 1'b0; bus_we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
        rexp_t e;
        e.exp = exp;
        e.nm  = nm;
        rq.push_back(e);
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(negedge clk);
        bus_sel = 1'b0;
    endtask

    task automatic wait_irq(input int lim, output int k);
        k = 0;
        while (!irq && k < lim) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic load_ops();
        wr(8'h20, 32'd5);  wr(8'h24, 32'd0);
        wr(8'h40, 32'd3);  wr(8'h44, 32'd0);
        wr(8'h60, 32'd11); wr(8'h64, 32'd0);
        wr(8'h80, NINV[31:0]); wr(8'h84, NINV[63:32]);
        wr(8'hA0, 32'd3);  wr(8'hA4, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        string       nm;
    } vec_t;
    vec_t tv[$];

    function automatic void add(input logic we, input logic [7:0] a, input logic [31:0] d,
                                input logic [31:0] exp, input string nm);
        vec_t v;
        v.we = we; v.a = a; v.d = d; v.exp = exp; v.nm = nm;
        tv.push_back(v);
    endfunction

    initial begin
        int k;
        rst = 1'b1; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;

        add(0, 8'h00, 0, 32'h0, "rst_ctrl");
        add(0, 8'h04, 0, 32'h0, "rst_status");
        add(0, 8'h08, 0, 32'h0, "rst_cycles");
        add(0, 8'h20, 0, 32'h0, "rst_m0");
        add(0, 8'h40, 0, 32'h0, "rst_e0");
        add(0, 8'h60, 0, 32'h0, "rst_n0");
        add(0, 8'h84, 0, 32'h0, "rst_ninv1");
        add(0, 8'hA0, 0, 32'h0, "rst_r2_0");
        add(0, 8'hC0, 0, 32'h0, "rst_c0");
        add(0, 8'hC4, 0, 32'h0, "rst_c1");
        add(1, 8'h20, 32'h1111_1111, 0, "");
        add(1, 8'h24, 32'h2222_2222, 0, "");
        add(0, 8'h20, 0, 32'h1111_1111, "m0_rt");
        add(0, 8'h24, 0, 32'h2222_2222, "m1_rt");
        add(1, 8'h38, 32'h5555_5555, 0, "");
        add(0, 8'h38, 0, 32'h0, "m_word6_unused");
        add(1, 8'h28, 32'h7777_7777, 0, "");
        add(0, 8'h28, 0, 32'h0, "m_word2_beyond");
        add(1, 8'h44, 32'hCAFE_F00D, 0, "");
        add(0, 8'h44, 0, 32'hCAFE_F00D, "e1_rt");
        add(1, 8'hE0, 32'h1234_5678, 0, "");
        add(0, 8'hE0, 0, 32'h0, "unmapped_e0");
        add(1, 8'hC0, 32'hDEAD_BEEF, 0, "");
        add(0, 8'hC0, 0, 32'h0, "c_readonly");
        add(1, 8'h00, 32'h2, 0, "");
        add(0, 8'h00, 0, 32'h2, "ctrl_irq_en");
        add(1, 8'h00, 32'h0, 0, "");
        add(0, 8'h00, 0, 32'h0, "ctrl_irq_dis");

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_rsa_start", {63'd0, rsa_start}, 64'd0);
        check("rst_irq", {63'd0, irq}, 64'd0);

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].we) wr(tv[i].a, tv[i].d);
            else rd(tv[i].a, tv[i].exp, tv[i].nm);
        end
        check("rsa_M_out", rsa_M, 64'h2222_2222_1111_1111);

        // Stub run with IRQ_EN
        wr(8'h00, 32'h3);
        check("start_pulse_hi", {63'd0, rsa_start}, 64'd1);
        rd(8'h04, 32'h1, "status_busy");
        check("start_pulse_lo", {63'd0, rsa_start}, 64'd0);
        wait_irq(60, k);
        check("done_latency", 64'(k + 1), 64'd21);
        check("one_pulse", 64'(pulses), 64'd1);
        rd(8'h04, 32'h2, "status_done");
        rd(8'hC0, 32'h89AB_CDEF, "c0");
        rd(8'hC4, 32'h0123_4567, "c1");
        rd(8'h08, 32'd20, "cycles20");
        wr(8'h00, 32'h6);
        check("irq_after_clr", {63'd0, irq}, 64'd0);
        rd(8'h04, 32'h0, "status_clr");

        // Engine done held high: busy writes flag ERR, second START ignored
        wr(8'h60, 32'h0000_000B);
        stub_hold = 1'b1;
        stub_c    = 64'hFEDC_BA98_7654_3210;
        wr(8'h00, 32'h3);
        wr(8'h60, 32'h0000_DEAD);
        wr(8'h00, 32'h3);
        rd(8'h04, 32'h5, "status_busy_err");
        rd(8'h60, 32'h0000_000B, "n_unchanged");
        repeat (30) @(negedge clk);
        check("no_second_pulse", 64'(pulses), 64'd2);
        check("no_done_on_level", {63'd0, irq}, 64'd0);
        rd(8'h04, 32'h5, "still_busy");
        stub_hold = 1'b0;
        wait_irq(60, k);
        check("fresh_edge_latency", 64'(k), 64'd21);
        rd(8'h04, 32'h6, "status_done_err");
        rd(8'hC0, 32'h7654_3210, "c0_hold_run");
        wr(8'h00, 32'h4);
        rd(8'h04, 32'h0, "status_clr2");
        rd(8'h00, 32'h0, "ctrl_irq_off");

        // Operand set with modexp result from the reference model
        use_model = 1'b1;
        load_ops();
        check("rsa_N_INV_out", rsa_N_INV, NINV);
        check("rsa_E_out", rsa_E, 64'd3);
        check("rsa_R2_out", rsa_R2, 64'd3);
        wr(8'h00, 32'h3);
        wait_irq(60, k);
        check("model_latency", 64'(k), 64'd21);
        rd(8'hC0, 32'd4, "modexp_c0");
        rd(8'hC4, 32'd0, "modexp_c1");
        rd(8'h04, 32'h2, "modexp_done");

        // Reset mid-run, then a clean run
        wr(8'h00, 32'h3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("irq_after_rst", {63'd0, irq}, 64'd0);
        check("start_after_rst", {63'd0, rsa_start}, 64'd0);
        rd(8'h04, 32'h0, "status_after_rst");
        rd(8'h08, 32'h0, "cycles_after_rst");
        rd(8'h20, 32'h0, "m0_after_rst");
        load_ops();
        wr(8'h00, 32'h3);
        wait_irq(60, k);
        check("rerun_latency", 64'(k), 64'd21);
        rd(8'hC0, 32'd4, "rerun_c0");
        rd(8'h08, 32'd20, "rerun_cycles");
        rd(8'h04, 32'h2, "rerun_done");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(rq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rsa_ctrl.md
# rsa_ctrl

Memory-mapped controller that lets the RV32I core configure, launch and collect results from the `rsa` modular-exponentiation engine. It holds the operand registers (M, E, N, N_INV, R2_MOD_N) as 32-bit words and sequences the engine's start/done handshake through a small FSM. It captures the result C, keeps a cycle counter, and raises an interrupt on completion. It sits between the core's peripheral bus and one `rsa` instance.

## Interface
- WIDTH, 64, operand width in bits; multiple of 32, max 256.
- E_BITS, 64, exponent width in bits; multiple of 32, max 256.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bus_sel  in  1  bus access this cycle.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  8  byte address; bits [1:0] ignored.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, valid one cycle after a read access.
- irq  out  1  level interrupt = DONE & IRQ_EN.
- rsa_start  out  1  one-cycle start pulse to the engine.
- rsa_M, rsa_N, rsa_N_INV, rsa_R2  out  WIDTH  operand registers, driven continuously.
- rsa_E  out  E_BITS  exponent register, driven continuously.
- rsa_C  in  WIDTH  engine result.
- rsa_done  in  1  engine completion level.

## Operation
- Register map (word-aligned; word k of an operand at base+4k, word 0 = bits [31:0]):
  - 0x00 CTRL (W): bit0 START (write 1), bit1 IRQ_EN (read/write), bit2 CLR (write 1 clears DONE and ERR).
  - 0x04 STATUS (R): bit0 BUSY, bit1 DONE, bit2 ERR.
  - 0x08 CYCLES (R): cycles spent in WAIT during the last run, saturating at 0xFFFFFFFF.
  - Operand bases: M at 0x20, E at 0x40, N at 0x60, N_INV at 0x80, R2 at 0xA0, C at 0xC0 (read-only).
  - Words beyond WIDTH/32 (E_BITS/32 for E) read 0 and ignore writes.
  - Unmapped addresses read 0 and ignore writes.
- FSM states:
  - IDLE: BUSY=0. A CTRL write with bit0=1 clears DONE and CYCLES, then goes to PULSE.
  - PULSE: rsa_start=1 for exactly one cycle, then goes to WAIT.
  - WAIT: CYCLES increments each cycle. Completion is a rising edge of rsa_done (rsa_done & ~done_q, with done_q a register of rsa_done). On completion, C is latched from rsa_C, DONE is set, and the FSM returns to IDLE.
- BUSY = 1 in PULSE and WAIT.
- While BUSY, writes to operand registers and START are ignored and set ERR; CTRL IRQ_EN and CLR writes still take effect.
- The C register holds its value until the next completion.
- Simultaneous events:
  - DONE set and CLR write in the same cycle: set wins.
  - CLR and START in the same write: clear applies, then the run starts.

## Timing
- Reset: FSM to IDLE. All operand registers, C, CYCLES, CTRL, DONE, ERR, done_q, bus_rdata, rsa_start and irq are 0.
- Reset mid-run: FSM returns to IDLE immediately and no DONE is set. The engine shares rst.
- START write at cycle t → PULSE at t+1 (rsa_start high during t+1) → WAIT from t+2.
- rsa_done rising at cycle d (sampled at edge d) → DONE, C and IDLE visible at d+1. irq is high at d+1 if IRQ_EN.
- A STATUS read in the same cycle as completion returns the pre-completion value.
- Read latency is 1 cycle. bus_rdata holds its last value when no read occurs.
- Write effect is visible to reads issued on the following cycle.

## Test plan
- Reset with rst=1 for 2 cycles: all registers read 0, rsa_start=0, irq=0.
- Register round-trip: write 0x11111111 to M word0 and 0x22222222 to M word1 → read back identical; rsa_M=64'h2222222211111111. A write to 0x38 reads 0.
- Stub engine (done rises 20 cycles after rsa_start, C=64'h0123456789ABCDEF), IRQ_EN=1, START → rsa_start high exactly one cycle; BUSY=1 during the run; then DONE=1, irq=1, C reads 0x89ABCDEF / 0x01234567, CYCLES=20. CLR → irq=0.
- With the stub engine held high after done: write to N while BUSY and a second START while BUSY → N unchanged, ERR=1, no second rsa_start pulse. A new START after DONE waits for a fresh rising edge.
- Real `rsa` with M=5, E=3, N=11, N_INV=15092790605762360413, R2=3 → C=4, DONE=1.
- Assert rst during WAIT → BUSY=0, DONE=0. A subsequent normal run completes correctly.
